// File: rtl/frame_scheduler.sv
// Game sequencer for the runner core: turns frame strobes and player input into
// per-frame update/start/game_rst pulses and keeps timer, speed and distance.
module frame_scheduler #(
    parameter int INIT_SPEED     = 6144,
    parameter int MAX_SPEED      = 13312,
    parameter int ACCEL          = 1,
    parameter int CLEAR_FRAMES   = 180,
    parameter int RESTART_FRAMES = 45,
    parameter int UPDATE_GAP     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        tick_ms,
    input  logic        jump,
    input  logic        crash,
    output logic        update,
    output logic [5:0]  timer,
    output logic        start,
    output logic        game_rst,
    output logic [14:0] speed,
    output logic        has_obstacles,
    output logic [25:0] distance,
    output logic        running
);

    localparam int GAP_W = (UPDATE_GAP > 2) ? $clog2(UPDATE_GAP) : 1;
    localparam int CLR_W = (CLEAR_FRAMES > 0) ? $clog2(CLEAR_FRAMES + 1) : 1;
    localparam int LCK_W = (RESTART_FRAMES > 0) ? $clog2(RESTART_FRAMES + 1) : 1;

    localparam logic [14:0]      INIT_S   = 15'(INIT_SPEED);
    localparam logic [14:0]      MAX_S    = 15'(MAX_SPEED);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(UPDATE_GAP - 1);
    localparam logic [CLR_W-1:0] CLR_MAX  = CLR_W'(CLEAR_FRAMES);
    localparam logic [LCK_W-1:0] LCK_MAX  = LCK_W'(RESTART_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUNNING,
        S_CRASHED,
        S_RESTART
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_issue;
    logic              w_start_nxt;
    logic              w_game_rst_nxt;
    logic              w_reinit;
    logic [15:0]       w_speed_sum;
    logic [14:0]       w_speed_inc;

    logic              r_update;
    logic              r_start;
    logic              r_game_rst;
    logic              r_pending;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [5:0]        r_ms_cnt;
    logic [5:0]        r_timer;
    logic [14:0]       r_speed;
    logic [25:0]       r_distance;
    logic [CLR_W-1:0]  r_clear_cnt;
    logic [LCK_W-1:0]  r_lock_cnt;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt    = r_state;
        w_issue        = 1'b0;
        w_start_nxt    = 1'b0;
        w_game_rst_nxt = 1'b0;
        w_reinit       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (jump) begin
                    w_state_nxt = S_RUNNING;
                    w_start_nxt = 1'b1;
                    w_reinit    = 1'b1;
                end
            end
            S_RUNNING: begin
                if (crash) begin
                    w_state_nxt = S_CRASHED;
                end else begin
                    w_issue = (frame_tick || r_pending) && (r_gap_cnt == '0);
                end
            end
            S_CRASHED: begin
                if (jump && (r_lock_cnt == LCK_MAX)) begin
                    w_state_nxt    = S_RESTART;
                    w_game_rst_nxt = 1'b1;
                end
            end
            S_RESTART: begin
                w_state_nxt = S_RUNNING;
                w_start_nxt = 1'b1;
                w_reinit    = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Saturating speed step; a speed already at or above the ceiling is held.
    always_comb begin
        w_speed_sum = {1'b0, r_speed} + 16'(ACCEL);
        if (r_speed >= MAX_S) begin
            w_speed_inc = r_speed;
        end else if (w_speed_sum > {1'b0, MAX_S}) begin
            w_speed_inc = MAX_S;
        end else begin
            w_speed_inc = w_speed_sum[14:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_update    <= 1'b0;
            r_start     <= 1'b0;
            r_game_rst  <= 1'b0;
            r_pending   <= 1'b0;
            r_gap_cnt   <= '0;
            r_ms_cnt    <= '0;
            r_timer     <= '0;
            r_speed     <= INIT_S;
            r_distance  <= '0;
            r_clear_cnt <= '0;
            r_lock_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_update   <= w_issue;
            r_start    <= w_start_nxt;
            r_game_rst <= w_game_rst_nxt;
            r_pending  <= (r_state == S_RUNNING) && !crash && !w_issue
                          && (frame_tick || r_pending);

            if (w_reinit) begin
                r_gap_cnt <= '0;
            end else if (w_issue) begin
                r_gap_cnt <= GAP_LOAD;
            end else if (r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end

            // A tick_ms coinciding with the update already belongs to the next interval.
            if (w_reinit) begin
                r_ms_cnt <= '0;
            end else if (w_issue) begin
                r_ms_cnt <= {5'd0, tick_ms};
            end else if ((r_state == S_RUNNING) && tick_ms && (r_ms_cnt != 6'd63)) begin
                r_ms_cnt <= r_ms_cnt + 6'd1;
            end

            if (w_issue) begin
                r_timer <= r_ms_cnt;
            end

            if (w_reinit) begin
                r_speed    <= INIT_S;
                r_distance <= '0;
            end else if (r_update) begin
                r_speed    <= w_speed_inc;
                r_distance <= r_distance + 26'(r_speed);
            end

            if (w_reinit) begin
                r_clear_cnt <= '0;
            end else if (w_issue && (r_clear_cnt != CLR_MAX)) begin
                r_clear_cnt <= r_clear_cnt + 1'b1;
            end

            if (w_reinit) begin
                r_lock_cnt <= '0;
            end else if ((r_state == S_CRASHED) && frame_tick && (r_lock_cnt != LCK_MAX)) begin
                r_lock_cnt <= r_lock_cnt + 1'b1;
            end
        end
    end

    assign update        = r_update;
    assign start         = r_start;
    assign game_rst      = r_game_rst;
    assign timer         = r_timer;
    assign speed         = r_speed;
    assign distance      = r_distance;
    assign has_obstacles = (r_clear_cnt == CLR_MAX);
    assign running       = (r_state == S_RUNNING);

endmodule
